// File: rtl/spram_bus_ctrl_pkg.sv
// spram_ctrl_pkg: shared types, widths and mask helper for the SPRAM bus controller
package spram_ctrl_pkg;
   localparam int SPRAM_ADDR_W = 14;
   localparam int SPRAM_DATA_W = 16;
   localparam int WORD_ADDR_W  = 13;
   typedef enum logic [3:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_DONE, RSP, SLEEP, WAKE} state_t;
   // byte b of a 16-bit half enables nibbles 2(b mod 2) and 2(b mod 2)+1
   function automatic logic [3:0] byte_to_nibble(input logic [1:0] m);
      return {{2{m[1]}}, {2{m[0]}}};
   endfunction
endpackage

// File: rtl/spram_bus_ctrl_if.sv
// spram_bus_ctrl_if: 32-bit word command/response bus between the data bus adapter and the SPRAM controller
//   cmd_valid/cmd_ready/cmd_write/cmd_address/cmd_data/cmd_mask : command channel
//   rsp_valid/rsp_ready/rsp_data                                : read response channel
//   master = bus adapter side, slave = controller side
interface spram_bus_ctrl_if;
   import spram_ctrl_pkg::*;
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_write;
   logic [WORD_ADDR_W-1:0] cmd_address;
   logic [31:0]            cmd_data;
   logic [3:0]             cmd_mask;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [31:0]            rsp_data;
   modport master (output cmd_valid, cmd_write, cmd_address, cmd_data, cmd_mask, rsp_ready,
                   input cmd_ready, rsp_valid, rsp_data);
   modport slave  (input cmd_valid, cmd_write, cmd_address, cmd_data, cmd_mask, rsp_ready,
                   output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/spram_bus_ctrl_power_seq.sv
// spram_power_seq: wake-up counting and optional idle standby for the SPRAM macro
//   clk, resetn       : clock, async active-low reset
//   state             : main FSM state
//   accept            : command accepted this cycle (only with SPRAM_AUTO_STANDBY_EN)
//   busy              : wake count still running (hold in WAKE)
//   sleep_ack         : macro is asleep
//   spram_sleep       : macro SLEEP pin
//   spram_standby     : macro STANDBY pin (tied 0 unless SPRAM_AUTO_STANDBY_EN)
module spram_power_seq import spram_ctrl_pkg::*; #(
   parameter int WAKE_CYCLES         = 3,
   parameter int STANDBY_IDLE_CYCLES = 8
) (
   input  logic   clk,
   input  logic   resetn,
   input  state_t state,
`ifdef SPRAM_AUTO_STANDBY_EN
   input  logic   accept,
`endif
   output logic   busy,
   output logic   sleep_ack,
   output logic   spram_sleep,
   output logic   spram_standby
);
   logic [3:0] wake_cnt;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) wake_cnt <= '0;
      else wake_cnt <= (state == WAKE) ? wake_cnt + 4'd1 : '0;
   // the last WAKE cycle is the one where the count hits WAKE_CYCLES-1
   assign busy        = (state == WAKE) && (wake_cnt != 4'(WAKE_CYCLES - 1));
   assign sleep_ack   = state == SLEEP;
   assign spram_sleep = state == SLEEP;
`ifdef SPRAM_AUTO_STANDBY_EN
   logic [7:0] idle_cnt;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) idle_cnt <= '0;
      else idle_cnt <= (state != IDLE || accept) ? '0 : idle_cnt + {7'd0, idle_cnt != 8'hFF};
   // accept drops STANDBY in the accept cycle so the first access sees the macro awake
   assign spram_standby = (state == IDLE) && !accept && (idle_cnt >= 8'(STANDBY_IDLE_CYCLES));
`else
   assign spram_standby = 1'b0;
`endif
endmodule

// File: rtl/spram_bus_ctrl.sv
// spram_bus_ctrl: 32-bit word initiator for one 16K x 16 iCE40UP SPRAM, two 16-bit accesses per word
//   clk, resetn          : clock, async active-low reset
//   bus (slave)          : command/response channel (spram_bus_ctrl_if)
//   sleep_req/sleep_ack  : level sleep request and acknowledge
//   spram_*              : SPRAM primitive pins, decoded from state and latched command only
//   Optional: SPRAM_AUTO_STANDBY_EN enables idle-driven STANDBY
module spram_bus_ctrl import spram_ctrl_pkg::*; #(
   parameter int WAKE_CYCLES         = 3,
   parameter int STANDBY_IDLE_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    resetn,
   spram_bus_ctrl_if.slave         bus,
   input  logic                    sleep_req,
   output logic                    sleep_ack,
   output logic [SPRAM_ADDR_W-1:0] spram_address,
   output logic [SPRAM_DATA_W-1:0] spram_datain,
   output logic [3:0]              spram_maskwren,
   output logic                    spram_wren,
   output logic                    spram_chipselect,
   output logic                    spram_standby,
   output logic                    spram_sleep,
   output logic                    spram_poweroff,
   input  logic [SPRAM_DATA_W-1:0] spram_dataout
);
   state_t                 state, nxt;
   logic [WORD_ADDR_W-1:0] addr_q;
   logic [31:0]            data_q;
   logic [3:0]             mask_q;
   logic                   accept, busy, hi, wr, acc;
   assign bus.cmd_ready = (state == IDLE) && !sleep_req;
   assign accept        = bus.cmd_valid && bus.cmd_ready;
   assign bus.rsp_valid = state == RSP;
   assign spram_poweroff = 1'b1;
   spram_power_seq #(.WAKE_CYCLES(WAKE_CYCLES), .STANDBY_IDLE_CYCLES(STANDBY_IDLE_CYCLES)) u_pwr (
      .clk, .resetn, .state,
`ifdef SPRAM_AUTO_STANDBY_EN
      .accept,
`endif
      .busy, .sleep_ack, .spram_sleep, .spram_standby);
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         addr_q       <= '0;
         data_q       <= '0;
         mask_q       <= '0;
         bus.rsp_data <= '0;
      end else begin
         if (accept) begin
            addr_q <= bus.cmd_address;
            data_q <= bus.cmd_data;
            mask_q <= bus.cmd_mask;
         end
         // macro read data appears the cycle after the address was presented
         if (state == RD_HI) bus.rsp_data[15:0] <= spram_dataout;
         if (state == RD_DONE) bus.rsp_data[31:16] <= spram_dataout;
      end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = sleep_req ? SLEEP : !bus.cmd_valid ? IDLE : !bus.cmd_write ? RD_LO :
                        |bus.cmd_mask[1:0] ? WR_LO : |bus.cmd_mask[3:2] ? WR_HI : IDLE;
         WR_LO:   nxt = |mask_q[3:2] ? WR_HI : IDLE;
         WR_HI:   nxt = IDLE;
         RD_LO:   nxt = RD_HI;
         RD_HI:   nxt = RD_DONE;
         RD_DONE: nxt = RSP;
         RSP:     nxt = bus.rsp_ready ? IDLE : RSP;
         SLEEP:   nxt = sleep_req ? SLEEP : WAKE;
         WAKE:    nxt = busy ? WAKE : sleep_req ? SLEEP : IDLE;
         default: nxt = IDLE;
      endcase
      hi               = (state == WR_HI) || (state == RD_HI);
      wr               = (state == WR_LO) || (state == WR_HI);
      acc              = wr || (state == RD_LO) || (state == RD_HI);
      spram_chipselect = acc;
      spram_wren       = wr;
      spram_address    = acc ? {addr_q, hi} : '0;
      spram_datain     = wr ? (hi ? data_q[31:16] : data_q[15:0]) : '0;
      spram_maskwren   = wr ? byte_to_nibble(hi ? mask_q[3:2] : mask_q[1:0]) : '0;
   end
endmodule

// File: tb/tb_spram_bus_ctrl.sv
// tb_spram_bus_ctrl: directed + randomized checks of spram_bus_ctrl against a 32-bit word memory model
module tb_spram_bus_ctrl;
   localparam int WAKE = 3;
   typedef struct {int cyc; logic wr; logic [13:0] a; logic [15:0] d; logic [3:0] m;} acc_t;
   logic        clk = 0;
   logic        resetn = 0;
   logic        sleep_req = 0;
   logic        sleep_ack;
   logic [13:0] spram_address;
   logic [15:0] spram_datain;
   logic [3:0]  spram_maskwren;
   logic        spram_wren, spram_chipselect, spram_standby, spram_sleep, spram_poweroff;
   logic [15:0] spram_dataout;
   logic [15:0] spram_mem [0:16383];
   logic [31:0] ref_mem [0:8191];
   acc_t        log_q[$];
   int          cyc = 0;
   int          acc_cyc = 0;
   int          tests = 0;
   int          fails = 0;
   spram_bus_ctrl_if bus();
   spram_bus_ctrl #(.WAKE_CYCLES(WAKE), .STANDBY_IDLE_CYCLES(8)) dut (
      .clk(clk), .resetn(resetn), .bus(bus.slave), .sleep_req(sleep_req), .sleep_ack(sleep_ack),
      .spram_address(spram_address), .spram_datain(spram_datain), .spram_maskwren(spram_maskwren),
      .spram_wren(spram_wren), .spram_chipselect(spram_chipselect), .spram_standby(spram_standby),
      .spram_sleep(spram_sleep), .spram_poweroff(spram_poweroff), .spram_dataout(spram_dataout));
   always #5 clk = ~clk;
   // behavioural SPRAM primitive: registered read, nibble-masked write
   always @(posedge clk) begin : macro
      logic [15:0] w;
      if (spram_chipselect && !spram_sleep) begin
         if (spram_wren) begin
            w = spram_mem[spram_address];
            for (int i = 0; i < 4; i++) if (spram_maskwren[i]) w[4*i +: 4] = spram_datain[4*i +: 4];
            spram_mem[spram_address] <= w;
         end else spram_dataout <= spram_mem[spram_address];
      end
   end
   always @(posedge clk) begin
      if (spram_chipselect) log_q.push_back('{cyc, spram_wren, spram_address, spram_datain, spram_maskwren});
      cyc++;
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // offer a command at a negedge, wait for acceptance, return in the cycle after the accept
   task automatic send(input logic w, input logic [12:0] a, input logic [31:0] d, input logic [3:0] m);
      int n = 0;
      bus.cmd_valid = 1; bus.cmd_write = w; bus.cmd_address = a; bus.cmd_data = d; bus.cmd_mask = m;
      #1;
      while (!bus.cmd_ready && n < 50) begin @(negedge clk); #1; n++; end
      if (n >= 50) chk("accept_timeout", 32'(n), 0);
      acc_cyc = cyc;
      if (w) for (int b = 0; b < 4; b++) if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      @(negedge clk);
      bus.cmd_valid = 0;
   endtask
   task automatic do_read(input logic [12:0] a, input int hold);
      logic [31:0] exp;
      exp = ref_mem[a];
      send(0, a, '0, '0);
      for (int i = 1; i < 4; i++) begin chk("rd_early", bus.rsp_valid, 0); @(negedge clk); end
      chk("rd_valid", bus.rsp_valid, 1);
      chk("rd_data", bus.rsp_data, exp);
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         chk("rsp_hold_valid", bus.rsp_valid, 1);
         chk("rsp_hold_data", bus.rsp_data, exp);
         chk("rsp_hold_ready", bus.cmd_ready, 0);
      end
      bus.rsp_ready = 1;
      @(negedge clk);
      bus.rsp_ready = 0;
      chk("rsp_done", bus.rsp_valid, 0);
   endtask
   initial begin
      bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_address = 0; bus.cmd_data = 0; bus.cmd_mask = 0;
      bus.rsp_ready = 0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_sleep_ack", sleep_ack, 0);
      chk("rst_ctrl", {spram_chipselect, spram_wren, spram_maskwren, spram_standby, spram_sleep}, 0);
      chk("rst_addr", spram_address, 0);
      chk("rst_datain", spram_datain, 0);
      chk("rst_poweroff", spram_poweroff, 1);
      resetn = 1;
      @(negedge clk);
      // full write: two macro writes on consecutive cycles, low half first
      log_q.delete();
      send(1, 13'h0005, 32'hDEADBEEF, 4'hF);
      repeat (3) @(negedge clk);
      chk("wr_count", log_q.size(), 2);
      if (log_q.size() == 2) begin
         chk("wr_lo", {log_q[0].wr, log_q[0].a, log_q[0].d, log_q[0].m}, {1'b1, 14'h000A, 16'hBEEF, 4'hF});
         chk("wr_hi", {log_q[1].wr, log_q[1].a, log_q[1].d, log_q[1].m}, {1'b1, 14'h000B, 16'hDEAD, 4'hF});
         chk("wr_lo_cyc", log_q[0].cyc, acc_cyc + 1);
         chk("wr_hi_cyc", log_q[1].cyc, acc_cyc + 2);
      end
      do_read(13'h0005, 1);
`ifdef SPRAM_AUTO_STANDBY_EN
      for (int i = 1; i <= 8; i++) begin chk("stby_early", spram_standby, 0); @(negedge clk); end
      chk("stby_on", spram_standby, 1);
      bus.cmd_valid = 1; bus.cmd_write = 0; bus.cmd_address = 13'h0005;
      #1;
      chk("stby_accept", spram_standby, 0);
      @(negedge clk);
      bus.cmd_valid = 0;
      chk("stby_access", spram_standby, 0);
      repeat (3) @(negedge clk);
      chk("stby_rd_valid", bus.rsp_valid, 1);
      bus.rsp_ready = 1;
      @(negedge clk);
      bus.rsp_ready = 0;
`else
      repeat (12) @(negedge clk);
      chk("stby_tied", spram_standby, 0);
`endif
      // high-half-only write
      log_q.delete();
      send(1, 13'h0005, 32'h00AA0000, 4'h4);
      repeat (3) @(negedge clk);
      chk("whi_count", log_q.size(), 1);
      if (log_q.size() == 1)
         chk("whi_acc", {log_q[0].wr, log_q[0].a, log_q[0].d, log_q[0].m}, {1'b1, 14'h000B, 16'h00AA, 4'h3});
      do_read(13'h0005, 1);
      chk("whi_ref", ref_mem[5], 32'hDEAABEEF);
      // empty mask: no macro access
      log_q.delete();
      send(1, 13'h0006, 32'h12345678, 4'h0);
      chk("w0_ready", bus.cmd_ready, 1);
      repeat (3) @(negedge clk);
      chk("w0_count", log_q.size(), 0);
      // long response stall
      do_read(13'h0005, 10);
      // sleep requested mid-read; also a command offered while sleep is pending
      send(0, 13'h0005, '0, '0);
      @(negedge clk);
      sleep_req = 1;
      repeat (2) @(negedge clk);
      chk("slp_rd_valid", bus.rsp_valid, 1);
      chk("slp_rd_data", bus.rsp_data, ref_mem[5]);
      chk("slp_ack_early", sleep_ack, 0);
      bus.rsp_ready = 1;
      bus.cmd_valid = 1; bus.cmd_write = 1; bus.cmd_address = 13'h0007; bus.cmd_data = 32'hCAFEF00D; bus.cmd_mask = 4'hF;
      log_q.delete();
      @(negedge clk);
      bus.rsp_ready = 0;
      chk("slp_idle_ready", bus.cmd_ready, 0);
      chk("slp_idle_valid", bus.rsp_valid, 0);
      @(negedge clk);
      chk("slp_ack", sleep_ack, 1);
      chk("slp_pin", spram_sleep, 1);
      chk("slp_cs", spram_chipselect, 0);
      repeat (3) @(negedge clk);
      chk("slp_no_access", log_q.size(), 0);
      bus.cmd_valid = 0;
      sleep_req = 0;
      for (int i = 1; i <= WAKE; i++) begin
         @(negedge clk);
         chk("wake_ready", bus.cmd_ready, 0);
         chk("wake_ack", {sleep_ack, spram_sleep}, 0);
      end
      @(negedge clk);
      chk("wake_done", bus.cmd_ready, 1);
      // sleep re-requested during wake
      sleep_req = 1;
      @(negedge clk);
      sleep_req = 0;
      @(negedge clk);
      sleep_req = 1;
      repeat (WAKE) @(negedge clk);
      chk("rewake_sleep", sleep_ack, 1);
      sleep_req = 0;
      repeat (WAKE + 1) @(negedge clk);
      chk("rewake_ready", bus.cmd_ready, 1);
      // reset in the middle of a write
      send(1, 13'h1FFF, 32'h12345678, 4'hF);
      chk("rstw_cs", {spram_chipselect, spram_wren}, 2'b11);
      resetn = 0;
      #1;
      chk("rstw_ctrl", {spram_chipselect, spram_wren, spram_maskwren, spram_standby, spram_sleep}, 0);
      chk("rstw_addr", {spram_address, spram_datain}, 0);
      chk("rstw_rsp", bus.rsp_valid, 0);
      @(negedge clk);
      resetn = 1;
      @(negedge clk);
      chk("rstw_ready", bus.cmd_ready, 1);
      // randomized traffic over a small address window
      for (int a = 0; a < 16; a++) send(1, 13'(a), $urandom, 4'hF);
      for (int k = 0; k < 40; k++) begin
         logic [12:0] a;
         a = 13'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            send(1, a, $urandom, 4'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end else do_read(a, $urandom_range(1, 3));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
